// File: rtl/dwconv_pkg.sv
// Shared types and helpers for the depthwise 3x3 conv + ReLU6 layer.
// Tap offsets are row-major over the 3x3 window; tap 0 is (dy,dx) = (-1,-1).
package dwconv_pkg;

   localparam int unsigned H_W  = 16;
   localparam int unsigned NCH  = 32;
   localparam int unsigned TAPS = 9;

   typedef enum logic [2:0] {
      S_IDLE,
      S_UP_START,
      S_UP_WAIT,
      S_FETCH,
      S_CAPTURE,
      S_REQUANT,
      S_DONE
   } state_t;

   function automatic logic signed [1:0] tap_dy(input logic [3:0] tap);
      case (tap)
         4'd0, 4'd1, 4'd2: return -2'sd1;
         4'd3, 4'd4, 4'd5: return 2'sd0;
         default:          return 2'sd1;
      endcase
   endfunction

   function automatic logic signed [1:0] tap_dx(input logic [3:0] tap);
      case (tap)
         4'd0, 4'd3, 4'd6: return -2'sd1;
         4'd1, 4'd4, 4'd7: return 2'sd0;
         default:          return 2'sd1;
      endcase
   endfunction

   function automatic logic [3:0] clamp_nib(input logic signed [15:0] v,
                                           input logic signed [15:0] hi);
      if (v < 16'sd0) return 4'd0;
      if (v > hi)     return hi[3:0];
      return v[3:0];
   endfunction

endpackage

// File: rtl/dwconv_out_mem.sv
// 1024x32 simple dual-port output RAM: port A writes whole words, port B
// returns one registered nibble (nibble 0 = bits [31:28]); collisions read old data.
module dwconv_out_mem (
   input  logic        clk,
   input  logic        resetn,
   input  logic        we,
   input  logic [9:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [9:0]  raddr,
   input  logic [2:0]  nsel,
   output logic [3:0]  rdata
);

   logic [31:0] mem_q [1024];
   logic [31:0] rword;
   logic [3:0]  rdata_d, rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   always_comb begin
      rword   = mem_q[raddr];
      rdata_d = 4'(rword >> {~nsel, 2'b00});
   end

   always_ff @(posedge clk) begin
      if (!resetn) rdata_q <= '0;
      else         rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dwconv3x3_relu6_16_16_32ch.sv
// Depthwise 3x3 conv (stride 1, zero pad 1) with shift requant and ReLU6 clamp
// over the upstream 16x16 maxpool map. Optional DWCONV_BIAS_EN adds per-channel bias.
module dwconv3x3_relu6_16_16_32ch
   import dwconv_pkg::*;
#(
   parameter int unsigned NUM_CH    = NCH,
   parameter int unsigned ACC_W     = 13,
   parameter int unsigned SHIFT     = 3,
   parameter int unsigned CLAMP_MAX = 6
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [4:0]  input_image_index,
   output logic        up_start,
   output logic [4:0]  up_image_index,
   input  logic        up_done,
   output logic [31:0] up_read_addr,
   input  logic [3:0]  up_read_data,
   input  logic        wt_we,
   input  logic [8:0]  wt_addr,
   input  logic [3:0]  wt_data,
   input  logic [31:0] read_addr,
   output logic [3:0]  read_data,
   output logic        busy,
   output logic        done
);

   state_t                  state_q, state_d;
   logic [4:0]              ch_q, ch_d;
   logic [3:0]              row_q, row_d, col_q, col_d, tap_q, tap_d;
   logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum, acc_shr;
   logic [31:0]             word_q, word_d;
   logic                    up_start_q, up_start_d, busy_q, busy_d;
   logic                    done_q, done_d, up_done_q, up_done_d;
   logic [3:0]              wt_q [NCH*TAPS];
   logic signed [1:0]       dy, dx;
   logic [5:0]              tap_r, tap_c;
   logic                    tap_inb, last_tap, last_pix;
   logic [8:0]              wt_idx;
   logic signed [8:0]       prod;
   logic [3:0]              nib;
   logic [4:0]              nib_sh;
   logic                    mem_we;
   logic [9:0]              mem_waddr;
   logic                    unused_addr_bits;

   always_ff @(posedge clk) begin
      if (wt_we && !busy_q && wt_addr < 9'(NCH*TAPS)) wt_q[wt_addr] <= wt_data;
   end

`ifdef DWCONV_BIAS_EN
   logic signed [7:0] bias_q [NCH];

   always_ff @(posedge clk) begin
      if (wt_we && !busy_q && wt_addr[8:5] == 4'b1001)
         bias_q[wt_addr[4:0]] <= {{4{wt_data[3]}}, wt_data};
   end
`endif

   // Window geometry: a 6-bit coordinate is in range iff its top two bits are clear.
   always_comb begin
      dy       = tap_dy(tap_q);
      dx       = tap_dx(tap_q);
      tap_r    = {2'b00, row_q} + {{4{dy[1]}}, dy};
      tap_c    = {2'b00, col_q} + {{4{dx[1]}}, dx};
      tap_inb  = (tap_r[5:4] == 2'b00) && (tap_c[5:4] == 2'b00);
      last_tap = (tap_q == 4'd8);
      last_pix = (ch_q == 5'(NUM_CH-1)) && (row_q == 4'hF) && (col_q == 4'hF);
      wt_idx   = 9'(ch_q) * 9'(TAPS) + 9'(tap_q);
      prod     = 9'($signed({1'b0, up_read_data})) * 9'($signed(wt_q[wt_idx]));
   end

   always_ff @(posedge clk) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (start) state_d = S_UP_START;
         S_UP_START: state_d = S_UP_WAIT;
         S_UP_WAIT:  if (up_done_q) state_d = S_FETCH;
         S_FETCH:    if (tap_inb) state_d = S_CAPTURE;
                     else if (last_tap) state_d = S_REQUANT;
         S_CAPTURE:  state_d = last_tap ? S_REQUANT : S_FETCH;
         S_REQUANT:  state_d = last_pix ? S_DONE : S_FETCH;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ch_d       = ch_q;
      row_d      = row_q;
      col_d      = col_q;
      tap_d      = tap_q;
      acc_d      = acc_q;
      word_d     = word_q;
      mem_we     = 1'b0;
`ifdef DWCONV_BIAS_EN
      acc_sum    = acc_q + ACC_W'(bias_q[ch_q]);
`else
      acc_sum    = acc_q;
`endif
      acc_shr    = acc_sum >>> SHIFT;
      nib        = clamp_nib(16'(acc_shr), 16'(CLAMP_MAX));
      nib_sh     = {~col_q[2:0], 2'b00};
      up_start_d = (state_d == S_UP_START);
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_q == S_DONE);
      up_done_d  = up_done && (state_q == S_UP_WAIT);
      case (state_q)
         S_IDLE: begin
            ch_d  = '0;
            row_d = '0;
            col_d = '0;
            tap_d = '0;
            acc_d = '0;
         end
         S_FETCH:   if (!tap_inb && !last_tap) tap_d = tap_q + 4'd1;
         S_CAPTURE: begin
            acc_d = acc_q + ACC_W'(prod);
            if (!last_tap) tap_d = tap_q + 4'd1;
         end
         S_REQUANT: begin
            word_d = (word_q & ~(32'hF << nib_sh)) | ({28'd0, nib} << nib_sh);
            mem_we = (col_q[2:0] == 3'd7);
            acc_d  = '0;
            tap_d  = '0;
            col_d  = col_q + 4'd1;
            if (col_q == 4'hF) begin
               row_d = row_q + 4'd1;
               if (row_q == 4'hF) ch_d = ch_q + 5'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         up_start_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         up_done_q  <= 1'b0;
         ch_q       <= '0;
         row_q      <= '0;
         col_q      <= '0;
         tap_q      <= '0;
         acc_q      <= '0;
         word_q     <= '0;
      end else begin
         up_start_q <= up_start_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         up_done_q  <= up_done_d;
         ch_q       <= ch_d;
         row_q      <= row_d;
         col_q      <= col_d;
         tap_q      <= tap_d;
         acc_q      <= acc_d;
         word_q     <= word_d;
      end
   end

   assign mem_waddr        = {ch_q, row_q, col_q[3]};
   assign up_start         = up_start_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign up_image_index   = input_image_index;
   assign up_read_addr     = (state_q == S_FETCH && tap_inb) ?
                             {19'd0, ch_q, tap_r[3:0], tap_c[3:0]} : '0;
   assign unused_addr_bits = ^read_addr[31:13];

   dwconv_out_mem u_out_mem (
      .clk    (clk),
      .resetn (resetn),
      .we     (mem_we),
      .waddr  (mem_waddr),
      .wdata  (word_d),
      .raddr  (read_addr[12:3]),
      .nsel   (read_addr[2:0]),
      .rdata  (read_data)
   );

endmodule

// File: tb/tb_dwconv3x3_relu6_16_16_32ch.sv
// Scoreboard bench for dwconv3x3_relu6_16_16_32ch (2-channel build) against a
// direct convolution model; DWCONV_BIAS_EN also enables the bias in the model.
module tb_dwconv3x3_relu6_16_16_32ch;

   localparam int NC  = 2;
   localparam int PIX = 256;

   logic        clk = 1'b0, resetn = 1'b0, start = 1'b0, up_done = 1'b0, wt_we = 1'b0;
   logic [4:0]  input_image_index = 5'd9;
   logic        up_start, busy, done;
   logic [4:0]  up_image_index;
   logic [31:0] up_read_addr;
   logic [3:0]  up_read_data = '0;
   logic [8:0]  wt_addr = '0;
   logic [3:0]  wt_data = '0;
   logic [31:0] read_addr = '0;
   logic [3:0]  read_data;

   dwconv3x3_relu6_16_16_32ch #(.NUM_CH(NC)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .start             (start),
      .input_image_index (input_image_index),
      .up_start          (up_start),
      .up_image_index    (up_image_index),
      .up_done           (up_done),
      .up_read_addr      (up_read_addr),
      .up_read_data      (up_read_data),
      .wt_we             (wt_we),
      .wt_addr           (wt_addr),
      .wt_data           (wt_data),
      .read_addr         (read_addr),
      .read_data         (read_data),
      .busy              (busy),
      .done              (done)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0, cyc = 0, up_start_cnt = 0;
   logic [3:0] img [8192];
   int w_m [288];
   int bias_m [32];
   int exp_out [NC*PIX];
   int exp_cycles;

   typedef struct {int addr; int exp;} rd_t;
   rd_t  sb[$];
   rd_t  mon_e;
   logic rd_req = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) up_read_data <= img[up_read_addr[12:0]];
   always @(posedge clk) if (up_start) up_start_cnt <= up_start_cnt + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (rd_req) begin
         #1;
         if (sb.size() == 0) check("sb_underflow", 1, 0);
         else begin
            mon_e = sb.pop_front();
            check($sformatf("rd[%0d]", mon_e.addr), int'(read_data), mon_e.exp);
         end
      end
   end

   task automatic write_wt(input int a, input int d);
      @(negedge clk);
      wt_we = 1'b1; wt_addr = 9'(a); wt_data = 4'(d);
      @(negedge clk);
      wt_we = 1'b0;
      if (a < 288) w_m[a] = d;
`ifdef DWCONV_BIAS_EN
      else if (a < 320) bias_m[a-288] = d;
`endif
   endtask

   task automatic compute_ref();
      int acc, y, rr, cc;
      exp_cycles = 0;
      for (int ch = 0; ch < NC; ch++)
         for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
               acc = 0;
               for (int dy = -1; dy <= 1; dy++)
                  for (int dx = -1; dx <= 1; dx++) begin
                     rr = r + dy; cc = c + dx;
                     if (rr >= 0 && rr < 16 && cc >= 0 && cc < 16) begin
                        acc += int'(img[ch*256 + rr*16 + cc]) * w_m[ch*9 + (dy+1)*3 + (dx+1)];
                        exp_cycles += 2;
                     end else exp_cycles += 1;
                  end
               exp_cycles += 1;
               acc += bias_m[ch];
               y = (acc - (((acc % 8) + 8) % 8)) / 8;
               if (y < 0) y = 0;
               if (y > 6) y = 6;
               exp_out[ch*256 + r*16 + c] = y;
            end
   endtask

   task automatic run_layer(input bit inject);
      int k, lat, cnt0;
      cnt0 = up_start_cnt;
      compute_ref();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("busy_after_start", busy, 1);
      check("up_start_pulse", up_start, 1);
      check("up_image_index", up_image_index, 9);
      up_done = 1'b1;                     // arrives while still in UP_START: must be ignored
      @(negedge clk); up_done = 1'b0;
      repeat (3) @(negedge clk);
      up_done = 1'b1;
      @(posedge clk); #1 k = cyc;
      @(negedge clk); up_done = 1'b0;
      lat = -1;
      for (int i = 0; i < exp_cycles + 200; i++) begin
         @(posedge clk); #1;
         if (inject && i == 3000) begin
            start = 1'b1; wt_we = 1'b1; wt_addr = 9'd4; wt_data = 4'd3;
         end
         if (inject && i == 3001) begin
            start = 1'b0; wt_we = 1'b0;
         end
         if (done) begin
            lat = cyc - k;
            break;
         end
      end
      check("done_latency", lat, exp_cycles + 2);
      check("busy_with_done", busy, 0);
      @(posedge clk); #1 check("done_one_cycle", done, 0);
      check("up_start_count", up_start_cnt - cnt0, 1);
   endtask

   task automatic read_all();
      rd_t e;
      for (int a = 0; a < NC*PIX; a++) begin
         @(negedge clk);
         read_addr = 32'(a); rd_req = 1'b1;
         e.addr = a; e.exp = exp_out[a];
         sb.push_back(e);
      end
      @(negedge clk); rd_req = 1'b0;
      repeat (2) @(negedge clk);
      check("sb_drained", sb.size(), 0);
   endtask

   task automatic fill_img(input int lo, input int hi);
      for (int i = 0; i < NC*PIX; i++) img[i] = 4'($urandom_range(hi, lo));
   endtask

   initial begin
      int seen;
      for (int i = 0; i < 32; i++) bias_m[i] = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_up_start", up_start, 0);
      check("rst_up_read_addr", up_read_addr, 0);
      check("rst_read_data", read_data, 0);
      @(negedge clk); resetn = 1'b1;

      for (int i = 0; i < NC*9; i++) write_wt(i, 0);
      fill_img(0, 15);
      run_layer(1'b0);
      read_all();

      for (int i = 0; i < NC*9; i++) write_wt(i, int'($urandom_range(15, 0)) - 8);
      write_wt(4, -5);
      fill_img(0, 15);
      run_layer(1'b1);
      read_all();

      for (int i = 0; i < NC*9; i++) write_wt(i, int'($urandom_range(1, 0)));
      write_wt(289, 5);
      fill_img(0, 15);
      run_layer(1'b0);
      read_all();

      for (int i = 0; i < NC*9; i++) write_wt(i, -1);
      fill_img(15, 15);
      run_layer(1'b0);
      read_all();

      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      up_done = 1'b1;
      @(negedge clk); up_done = 1'b0;
      repeat (6000) @(negedge clk);
      check("abort_busy_before", busy, 1);
      resetn = 1'b0;
      @(posedge clk); #1;
      check("abort_busy", busy, 0);
      check("abort_up_read_addr", up_read_addr, 0);
      @(negedge clk); resetn = 1'b1;
      seen = 0;
      repeat (4000) begin
         @(posedge clk); #1;
         if (done || busy) seen = 1;
      end
      check("abort_no_done", seen, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
